// File: rtl/param_data_memory_pkg.sv
// param_data_memory_pkg: shared FSM encoding and default sizing for param_data_memory.
package param_data_memory_pkg;
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_IDLE = 1'b1;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
endpackage

// File: rtl/param_data_memory_mem_array.sv
// mem_array: single-write-port storage, synchronous write, combinational read, no reset.
module mem_array #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/param_data_memory.sv
// param_data_memory: word memory with power-on/on-demand clear sweep and 1-cycle registered reads.
module param_data_memory
  import param_data_memory_pkg::*;
#(
  parameter int               DATA_W   = DEF_DATA_W,
  parameter int               ADDR_W   = DEF_ADDR_W,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
  output logic              ready,
  output logic              busy,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);
  logic [0:0]        state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem_q;
  logic              rd_go;
  logic              wr_go;
  assign busy  = state == ST_CLEAR;
  assign ready = state == ST_IDLE;
  // clr wins over a same-cycle request
  assign rd_go = ready & req & ~we & ~clr;
  assign wr_go = ready & req & we & ~clr;
  mem_array #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mem (
    .clk   (clk),
    .we    (busy | wr_go),
    .waddr (busy ? cnt : addr),
    .wdata (busy ? INIT_VAL : wdata),
    .raddr (addr),
    .rdata (mem_q)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state  <= ST_CLEAR;
      cnt    <= '0;
      rvalid <= 1'b0;
      rdata  <= '0;
    end else begin
      rvalid <= rd_go;
      if (rd_go) rdata <= mem_q;
      if (busy) begin
        cnt <= cnt + 1'b1;
        if (cnt == {ADDR_W{1'b1}}) state <= ST_IDLE;
      end else if (clr) begin
        state <= ST_CLEAR;
        cnt   <= '0;
      end
    end
endmodule

// File: tb/tb_param_data_memory.sv
// tb_param_data_memory: directed scoreboard bench for param_data_memory (8-bit words, 16 deep).
module tb_param_data_memory;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req = 1'b0;
  logic       we = 1'b0;
  logic [3:0] addr = '0;
  logic [7:0] wdata = '0;
  logic       clr = 1'b0;
  logic       ready, busy, rvalid;
  logic [7:0] rdata;
  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];
  int n;

  param_data_memory #(.DATA_W(8), .ADDR_W(4), .INIT_VAL(8'hA5)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .clr(clr), .ready(ready), .busy(busy), .rvalid(rvalid), .rdata(rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one request per call: drive, let one rising edge take it, then release
  task automatic op(input logic r, input logic w, input logic c, input logic [3:0] a, input logic [7:0] d);
    req = r; we = w; clr = c; addr = a; wdata = d;
    @(posedge clk);
    #1;
    req = 1'b0; we = 1'b0; clr = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [7:0] e);
    exp_q.push_back(e);
    op(1'b1, 1'b0, 1'b0, a, 8'h00);
  endtask

  task automatic wait_sweep(output int cycles);
    cycles = 0;
    forever begin
      @(negedge clk);
      if (!busy || cycles > 100) break;
      cycles++;
    end
    if (cycles > 100) chk("sweep_timeout", 32'(cycles), 32'd16);
  endtask

  always @(negedge clk)
    if (rvalid) begin
      if (exp_q.size() == 0) chk("unexpected_rvalid", 32'(rvalid), 32'd0);
      else chk("rdata", 32'(rdata), 32'(exp_q.pop_front()));
    end

  initial begin
    #2;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_sweep(n);
    chk("init_sweep_len", 32'(n), 32'd16);
    chk("ready_after_sweep", 32'(ready), 32'd1);
    for (int i = 0; i < 16; i++) rd(4'(i), 8'hA5);
    op(1'b1, 1'b1, 1'b0, 4'd4, 8'h3C);
    rd(4'd4, 8'h3C);
    op(1'b1, 1'b1, 1'b0, 4'd1, 8'h11);
    op(1'b1, 1'b1, 1'b0, 4'd2, 8'h22);
    op(1'b1, 1'b1, 1'b0, 4'd3, 8'h33);
    rd(4'd1, 8'h11);
    rd(4'd2, 8'h22);
    rd(4'd3, 8'h33);
    repeat (3) @(negedge clk);
    chk("rdata_hold", 32'(rdata), 32'h33);
    chk("rvalid_idle", 32'(rvalid), 32'd0);
    // read immediately before clr must still complete; same-cycle write is dropped
    rd(4'd4, 8'h3C);
    op(1'b1, 1'b1, 1'b1, 4'd7, 8'hFF);
    chk("clr_busy", 32'(busy), 32'd1);
    wait_sweep(n);
    chk("clr_sweep_len", 32'(n), 32'd16);
    rd(4'd7, 8'hA5);
    rd(4'd4, 8'hA5);
    rd(4'd1, 8'hA5);
    // requests during the sweep must be ignored
    op(1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
    repeat (10) @(negedge clk);
    chk("busy_midsweep", 32'(busy), 32'd1);
    op(1'b1, 1'b1, 1'b0, 4'd2, 8'hFF);
    op(1'b1, 1'b0, 1'b0, 4'd3, 8'h00);
    wait_sweep(n);
    rd(4'd2, 8'hA5);
    rd(4'd3, 8'hA5);
    op(1'b1, 1'b1, 1'b0, 4'd15, 8'h5A);
    rd(4'd15, 8'h5A);
    // reset in the middle of a sweep
    op(1'b0, 1'b0, 1'b1, 4'd0, 8'h00);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd1);
    chk("midrst_ready", 32'(ready), 32'd0);
    chk("midrst_rvalid", 32'(rvalid), 32'd0);
    chk("midrst_rdata", 32'(rdata), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    wait_sweep(n);
    chk("rst_sweep_len", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) rd(4'(i), 8'hA5);
    repeat (3) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/param_data_memory.md
PARAM_DATA_MEMORY -- requirements
Module: param_data_memory

Interface
REQ-001 Parameter DATA_W, default 8, word width in bits.
REQ-002 Parameter ADDR_W, default 8, address width; depth = 2**ADDR_W words.
REQ-003 Parameter INIT_VAL, default 0, DATA_W-bit value written to every word by a clear sweep.
REQ-004 clk  input  1  system clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  1  access request, sampled only while ready=1.
REQ-007 we  input  1  with req: 1 = write, 0 = read.
REQ-008 addr  input  ADDR_W  word address.
REQ-009 wdata  input  DATA_W  write data.
REQ-010 clr  input  1  single-cycle request to re-run the clear sweep.
REQ-011 ready  output  1  block accepts req this cycle.
REQ-012 busy  output  1  clear sweep in progress.
REQ-013 rvalid  output  1  one-cycle pulse, rdata valid.
REQ-014 rdata  output  DATA_W  registered read data.

Function
REQ-015 Two-state FSM, CLEAR and IDLE; state after reset is CLEAR.
REQ-016 CLEAR: internal sweep counter starts at 0 and writes INIT_VAL to one word per cycle, incrementing by 1.
REQ-017 CLEAR -> IDLE on the cycle the word at address 2**ADDR_W-1 is written; sweep takes exactly 2**ADDR_W cycles.
REQ-018 In CLEAR: busy=1, ready=0; req, we and clr are ignored.
REQ-019 In IDLE: busy=0, ready=1.
REQ-020 IDLE, req=1, we=1: mem[addr] <= wdata at that rising edge; no rvalid.
REQ-021 IDLE, req=1, we=0: rdata <= mem[addr] and rvalid=1 in the following cycle; read latency 1 cycle.
REQ-022 Back-to-back reads are accepted every cycle; rvalid stays high for consecutive reads.
REQ-023 A read in the cycle after a write to the same address returns the newly written data.
REQ-024 rdata holds its last value when rvalid=0.
REQ-025 IDLE, clr=1: enter CLEAR next cycle with counter at 0; clr has priority and a req in the same cycle is dropped.
REQ-026 A read accepted in the cycle before clr still produces its rvalid pulse.
REQ-027 Address wrap: counter is ADDR_W+1 bits or uses a terminal compare; no out-of-range access is possible.

Reset
REQ-028 rst_n=0 forces immediately: state=CLEAR, counter=0, rvalid=0, rdata=0, busy=1, ready=0.
REQ-029 Memory array is not reset directly; its contents are defined only after the sweep completes.
REQ-030 Reset asserted mid-sweep or mid-read aborts it; the full sweep restarts on rst_n release.

Structure
REQ-031 Shared package holds the FSM state encoding (ST_CLEAR, ST_IDLE) and default parameter constants.
REQ-032 Storage lives in one sub-module, mem_array: a single-write-port array with synchronous write and combinational read, no reset.
REQ-033 param_data_memory contains the FSM, sweep counter, write-port mux (sweep vs. user) and read register.

Verification (DATA_W=8, ADDR_W=4, INIT_VAL=8'hA5)
REQ-034 Release rst_n -> busy=1 for exactly 16 cycles, then ready=1; reads of addr 0..15 all return 8'hA5.
REQ-035 Write 8'h3C @ addr 4, then read addr 4 next cycle -> rvalid one cycle later, rdata=8'h3C.
REQ-036 Reads of addrs 1, 2, 3 on consecutive cycles after writing 8'h11, 8'h22, 8'h33 -> rvalid high 3 cycles, rdata 11, 22, 33 in order.
REQ-037 Pulse clr with req=1, we=1, addr 7, wdata 8'hFF in the same cycle -> write dropped, 16-cycle sweep, then addr 7 reads 8'hA5.
REQ-038 Assert rst_n=0 at sweep cycle 8 -> outputs take reset values immediately; after release, sweep runs a full 16 cycles from address 0.
REQ-039 Issue req during busy=1 -> no write and no rvalid; memory contents unchanged after the sweep.
